// File: rtl/diff_cal_ctrl.sv
// Offset-calibration sequencer: shorts the comparator inputs, then runs a
// successive-approximation search over the trim DAC using majority-voted samples.
module diff_cal_ctrl #(
    parameter int TRIM_W     = 6,
    parameter int SETTLE_CYC = 16,
    parameter int SAMPLES    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cmp_in,
    output logic [TRIM_W-1:0] trim,
    output logic              short_en,
    output logic              busy,
    output logic              done,
    output logic              cmp_out
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_SAMPLE = 3'd2;
    localparam logic [2:0] ST_DECIDE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam int CNT_MAX = (SETTLE_CYC > SAMPLES) ? SETTLE_CYC : SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int ONES_W  = $clog2(SAMPLES + 1);
    localparam int K_W     = $clog2(TRIM_W);

    localparam logic [TRIM_W-1:0] MIDSCALE    = {1'b1, {(TRIM_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLES - 1);
    localparam logic [ONES_W-1:0] MAJ_THR     = ONES_W'(SAMPLES / 2);
    localparam logic [K_W-1:0]    K_MSB       = K_W'(TRIM_W - 1);

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [ONES_W-1:0] ones;
    logic [K_W-1:0]    bit_idx;
    logic [TRIM_W-1:0] trim_dec;
    logic              cmp_meta;
    logic              cmp_s;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values; = here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmp_meta <= 1'b0;
            cmp_s    <= 1'b0;
        end else begin
            cmp_meta <= cmp_in;
            cmp_s    <= cmp_meta;
        end
    end

    assign cmp_out = cmp_s;

    // NOTE: default assignment first so no path through the block leaves
    // trim_dec unassigned, which would otherwise infer a latch.
    always_comb begin
        trim_dec = trim;
        if (ones > MAJ_THR)
            trim_dec[bit_idx] = 1'b0;
        if (bit_idx != '0)
            trim_dec[bit_idx - 1'b1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            trim     <= MIDSCALE;
            short_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            ones     <= '0;
            bit_idx  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        trim     <= MIDSCALE;
                        bit_idx  <= K_MSB;
                        busy     <= 1'b1;
                        short_en <= 1'b1;
                        done     <= 1'b0;
                        cnt      <= '0;
                        state    <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        ones  <= '0;
                        state <= ST_SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    ones <= ones + cmp_s;
                    if (cnt == SAMPLE_LAST) begin
                        cnt   <= '0;
                        state <= ST_DECIDE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DECIDE: begin
                    trim <= trim_dec;
                    if (bit_idx != '0) begin
                        bit_idx <= bit_idx - 1'b1;
                        state   <= ST_SETTLE;
                    end else begin
                        busy     <= 1'b0;
                        short_en <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_diff_cal_ctrl.sv
// Self-checking bench for diff_cal_ctrl: stuck, threshold, majority, start
// handling and reset scenarios against a search-level reference model.
module tb_diff_cal_ctrl;

    localparam int TRIM_W   = 6;
    localparam int BIT_CYC  = 16 + 5 + 1;
    localparam int CAL_CYC  = TRIM_W * BIT_CYC;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             cmp_drv;
    logic             use_thr;
    logic [6:0]       thr;
    logic             cmp_in;
    logic [TRIM_W-1:0] trim;
    logic             short_en;
    logic             busy;
    logic             done;
    logic             cmp_out;

    int checks   = 0;
    int failures = 0;

    assign cmp_in = use_thr ? ({1'b0, trim} >= thr) : cmp_drv;

    diff_cal_ctrl #(.TRIM_W(TRIM_W), .SETTLE_CYC(16), .SAMPLES(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmp_in(cmp_in),
        .trim(trim), .short_en(short_en), .busy(busy), .done(done),
        .cmp_out(cmp_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns after the edge that samples start, i.e. just after T0.
    task automatic start_cal();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Bounded wait for done; counts cycles after the current edge and busy-high samples.
    task automatic wait_done(output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        while (done !== 1'b1 && n < 400) begin
            if (busy === 1'b1) busy_n++;
            tick();
            n++;
        end
    endtask

    // Reference: the result is the largest code the threshold comparator reads as 0.
    function automatic int model_result(input int t);
        int r = 0;
        for (int c = 0; c < (1 << TRIM_W); c++)
            if (!(c >= t)) r = c;
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; use_thr = 1'b0; cmp_drv = 1'b1; thr = '0;
        tick(); tick();
        checks++;
        if (trim !== 6'd32 || short_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmp_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: trim=%0d short_en=%b busy=%b done=%b cmp_out=%b, want 32/0/0/0/0",
                     trim, short_en, busy, done, cmp_out);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (cmp_out !== 1'b0) begin
            failures++;
            $display("FAIL sync_lat1: cmp_out=%b want 0", cmp_out);
        end
        tick();
        checks++;
        if (cmp_out !== 1'b1) begin
            failures++;
            $display("FAIL sync_lat2: cmp_out=%b want 1", cmp_out);
        end
    endtask

    task automatic test_stuck(input logic level);
        int n, bn;
        int want = level ? 0 : 63;
        use_thr = 1'b0;
        cmp_drv = level;
        start_cal();
        checks++;
        if (busy !== 1'b1 || short_en !== 1'b1 || trim !== 6'd32) begin
            failures++;
            $display("FAIL start_outputs: busy=%b short_en=%b trim=%0d want 1/1/32", busy, short_en, trim);
        end
        wait_done(n, bn);
        checks++;
        if (n !== CAL_CYC || bn !== CAL_CYC) begin
            failures++;
            $display("FAIL stuck_timing: done_after=%0d busy_cycles=%0d want %0d", n, bn, CAL_CYC);
        end
        checks++;
        if (trim !== 6'(want) || short_en !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL stuck_result(%b): trim=%0d short_en=%b busy=%b done=%b want %0d/0/0/1",
                     level, trim, short_en, busy, done, want);
        end
    endtask

    task automatic test_threshold(input int t, input bit check_seq);
        int n, bn, code;
        int seq[TRIM_W];
        code = 1 << (TRIM_W - 1);
        for (int b = TRIM_W - 1; b >= 0; b--) begin
            seq[TRIM_W - 1 - b] = code;
            if (code >= t) code &= ~(1 << b);
            if (b > 0) code |= 1 << (b - 1);
        end
        use_thr = 1'b1;
        thr = 7'(t);
        start_cal();
        if (check_seq) begin
            for (int s = 0; s < TRIM_W; s++) begin
                checks++;
                if (trim !== 6'(seq[s])) begin
                    failures++;
                    $display("FAIL trim_seq[%0d]: trim=%0d want %0d", s, trim, seq[s]);
                end
                if (s < TRIM_W - 1) repeat (BIT_CYC) tick();
            end
        end
        wait_done(n, bn);
        checks++;
        if (trim !== 6'(model_result(t)) || (n + (check_seq ? (TRIM_W - 1) * BIT_CYC : 0)) !== CAL_CYC) begin
            failures++;
            $display("FAIL threshold(%0d): trim=%0d want %0d, cycles=%0d", t, trim, model_result(t), n);
        end
        use_thr = 1'b0;
    endtask

    task automatic test_majority(input logic [4:0] mask);
        int n, bn;
        logic msb_kept = ($countones(mask) <= 2);
        use_thr = 1'b0;
        cmp_drv = 1'b0;
        start_cal();
        for (int j = 0; j < BIT_CYC; j++) begin
            cmp_drv = (j >= 14 && j <= 18) ? mask[j - 14] : 1'b0;
            tick();
        end
        cmp_drv = 1'b0;
        checks++;
        if (trim !== (msb_kept ? 6'd48 : 6'd16)) begin
            failures++;
            $display("FAIL majority_msb(%b): trim=%0d want %0d", mask, trim, msb_kept ? 48 : 16);
        end
        wait_done(n, bn);
        checks++;
        if (trim !== (msb_kept ? 6'd63 : 6'd31)) begin
            failures++;
            $display("FAIL majority_final(%b): trim=%0d want %0d", mask, trim, msb_kept ? 63 : 31);
        end
    endtask

    task automatic test_start_ignored();
        int n, bn;
        use_thr = 1'b0;
        cmp_drv = 1'b0;
        start_cal();
        repeat (49) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n, bn);
        checks++;
        if (50 + n !== CAL_CYC || trim !== 6'd63) begin
            failures++;
            $display("FAIL start_ignored: done_after=%0d trim=%0d want %0d/63", 50 + n, trim, CAL_CYC);
        end
    endtask

    task automatic test_start_held();
        int n, bn;
        use_thr = 1'b0;
        cmp_drv = 1'b1;
        start = 1'b1;
        tick();
        wait_done(n, bn);
        checks++;
        if (n !== CAL_CYC || trim !== 6'd0) begin
            failures++;
            $display("FAIL held_first: done_after=%0d trim=%0d want %0d/0", n, trim, CAL_CYC);
        end
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || trim !== 6'd32) begin
            failures++;
            $display("FAIL held_restart: done=%b busy=%b trim=%0d want 0/1/32", done, busy, trim);
        end
        wait_done(n, bn);
        checks++;
        if (n !== CAL_CYC || done !== 1'b1) begin
            failures++;
            $display("FAIL held_second: done_after=%0d want %0d", n, CAL_CYC);
        end
    endtask

    task automatic test_reset_mid();
        int n, bn;
        int t;
        use_thr = 1'b0;
        cmp_drv = 1'b1;
        start_cal();
        repeat (69) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (trim !== 6'd32 || short_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: trim=%0d short_en=%b busy=%b done=%b want 32/0/0/0",
                     trim, short_en, busy, done);
        end
        rst_n = 1'b1;
        tick();
        t = $urandom_range(1, 63);
        use_thr = 1'b1;
        thr = 7'(t);
        start_cal();
        wait_done(n, bn);
        checks++;
        if (n !== CAL_CYC || trim !== 6'(model_result(t))) begin
            failures++;
            $display("FAIL reset_recover(%0d): done_after=%0d trim=%0d want %0d/%0d",
                     t, n, trim, CAL_CYC, model_result(t));
        end
        use_thr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stuck(1'b0);
        test_stuck(1'b1);
        test_threshold(38, 1'b1);
        test_threshold(0, 1'b0);
        test_threshold(64, 1'b0);
        for (int i = 0; i < 6; i++)
            test_threshold($urandom_range(0, 64), 1'b0);
        test_majority(5'b10001);
        test_majority(5'b10101);
        for (int i = 0; i < 4; i++)
            test_majority(5'($urandom_range(0, 31)));
        test_start_ignored();
        test_start_held();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
